pll_reconfig_sequencer: RTL

- Controls the board's PLLVR instance from the free-running 27 MHz input clock domain.
- Drives the PLL reset pin and the dynamic divider selects (IDSEL/FBDSEL/ODSEL), choosing among up to four pixel-clock modes.
- Qualifies LOCK with a synchronizer and a stability counter, retries on lock timeout or lock loss, and reports ready or fault.
- Downstream HDMI/TM1638 logic holds itself in reset until ready is high.

---
 rtl/pll_reconfig_pkg.sv | 33 +++
 rtl/pll_lock_sync.sv | 25 ++
 rtl/pll_reconfig_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/pll_reconfig_pkg.sv
// Shared types and the pixel-clock mode table for the PLLVR reconfiguration sequencer.
// All divider codes are pre-encoded for the PLLVR dynamic pins (IDSEL/FBDSEL = 64 - div, ODSEL = 64 - div/2).
package pll_reconfig_pkg;

   typedef enum logic [2:0] {
      StHold,
      StWaitLock,
      StStable,
      StReady,
      StFault
   } state_e;

   typedef struct packed {
      logic [5:0] idsel;
      logic [5:0] fbdsel;
      logic [5:0] odsel;
   } mode_entry_t;

   localparam int unsigned NumModes = 4;

   // Modes from the 27 MHz input; VCO = out * ODIV must stay in the PLLVR VCO range.
   function automatic mode_entry_t mode_entry(input logic [1:0] idx);
      mode_entry_t e;
      case (idx)
         2'd0:    e = '{idsel: 6'd49, fbdsel: 6'd50, odsel: 6'd48}; // 27*14/15 = 25.2 MHz, ODIV 32
         2'd1:    e = '{idsel: 6'd60, fbdsel: 6'd53, odsel: 6'd60}; // 27*11/4 = 74.25 MHz, ODIV 8
         2'd2:    e = '{idsel: 6'd63, fbdsel: 6'd63, odsel: 6'd48}; // 27*1/1 = 27 MHz, ODIV 32
         default: e = '{idsel: 6'd37, fbdsel: 6'd24, odsel: 6'd56}; // 27*40/27 = 40 MHz, ODIV 16
      endcase
      return e;
   endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL LOCK pin into the clk domain.
// Both flops clear on rst so a fresh sequence never sees a stale lock.
module pll_lock_sync (
   input  logic clk,
   input  logic rst,
   input  logic lock_async,
   output logic lock_sync
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= lock_async;
         sync_q <= meta_q;
      end
   end

   assign lock_sync = sync_q;

endmodule

// File: rtl/pll_reconfig_sequencer.sv
// Sequences PLLVR reset and dynamic divider selects, qualifies LOCK, retries on failure
// and reports ready/fault. Runs entirely on the free-running 27 MHz input clock.
module pll_reconfig_sequencer
   import pll_reconfig_pkg::*;
#(
   parameter int unsigned RESET_PULSE_CYCLES  = 16,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 27000,
   parameter int unsigned LOCK_STABLE_CYCLES  = 270,
   parameter int unsigned MAX_RETRIES         = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] mode_sel,
   input  logic       mode_req,
   input  logic       pll_lock,
   output logic       pll_reset,
   output logic [5:0] pll_idsel,
   output logic [5:0] pll_fbdsel,
   output logic [5:0] pll_odsel,
   output logic [1:0] mode_cur,
   output logic       ready,
   output logic       busy,
   output logic       error,
   output logic [1:0] retry_cnt
);

   localparam int unsigned MaxA      = (RESET_PULSE_CYCLES > LOCK_STABLE_CYCLES) ?
                                       RESET_PULSE_CYCLES : LOCK_STABLE_CYCLES;
   localparam int unsigned MaxCycles = (MaxA > LOCK_TIMEOUT_CYCLES) ? MaxA : LOCK_TIMEOUT_CYCLES;
   localparam int unsigned CntW      = $clog2(MaxCycles + 1);

   state_e        state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [CntW-1:0] stab_q, stab_d;
   logic [CntW-1:0] stab_inc;
   logic [1:0]    retry_q, retry_d;
   logic [1:0]    retry_inc;
   logic [1:0]    mode_q, mode_d;
   mode_entry_t   codes_q;
   logic          pll_reset_q;
   logic          ready_q;
   logic          busy_q;
   logic          error_q;
   logic          lock_s;
   logic          hold_entry;

   pll_lock_sync u_lock_sync (
      .clk        (clk),
      .rst        (rst),
      .lock_async (pll_lock),
      .lock_sync  (lock_s)
   );

   assign stab_inc   = stab_q + CntW'(1);
   assign retry_inc  = retry_q + 2'd1;
   assign hold_entry = (state_d == StHold) && (state_q != StHold);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stab_d  = stab_q;
      retry_d = retry_q;
      mode_d  = mode_q;
      unique case (state_q)
         StHold: begin
            if (cnt_q == CntW'(RESET_PULSE_CYCLES - 1)) begin
               state_d = StWaitLock;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         // The timeout counter runs across WAIT_LOCK/STABLE bounces; only stab_q restarts.
         StWaitLock, StStable: begin
            if (lock_s && (stab_inc == CntW'(LOCK_STABLE_CYCLES))) begin
               state_d = StReady;
               cnt_d   = '0;
               stab_d  = '0;
            end else if (cnt_q == CntW'(LOCK_TIMEOUT_CYCLES - 1)) begin
               retry_d = retry_inc;
               cnt_d   = '0;
               stab_d  = '0;
               state_d = (retry_inc == 2'(MAX_RETRIES)) ? StFault : StHold;
            end else begin
               cnt_d   = cnt_q + CntW'(1);
               stab_d  = lock_s ? stab_inc : '0;
               state_d = lock_s ? StStable : StWaitLock;
            end
         end
         // A request beats a simultaneous lock loss so the new mode is never dropped.
         StReady, StFault: begin
            if (mode_req) begin
               mode_d  = mode_sel;
               retry_d = '0;
               state_d = StHold;
            end else if ((state_q == StReady) && !lock_s) begin
               retry_d = '0;
               state_d = StHold;
            end
         end
         default: state_d = StHold;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StHold;
         cnt_q       <= '0;
         stab_q      <= '0;
         retry_q     <= '0;
         mode_q      <= '0;
         codes_q     <= mode_entry(2'd0);
         pll_reset_q <= 1'b1;
         ready_q     <= 1'b0;
         busy_q      <= 1'b1;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stab_q      <= stab_d;
         retry_q     <= retry_d;
         mode_q      <= mode_d;
         // Codes only move while the PLL is about to be held in reset.
         if (hold_entry) begin
            codes_q <= mode_entry(mode_d);
         end
         pll_reset_q <= (state_d == StHold) || (state_d == StFault);
         ready_q     <= (state_d == StReady);
         busy_q      <= (state_d == StHold) || (state_d == StWaitLock) || (state_d == StStable);
         error_q     <= (state_d == StFault);
      end
   end

   assign pll_reset  = pll_reset_q;
   assign pll_idsel  = codes_q.idsel;
   assign pll_fbdsel = codes_q.fbdsel;
   assign pll_odsel  = codes_q.odsel;
   assign mode_cur   = mode_q;
   assign ready      = ready_q;
   assign busy       = busy_q;
   assign error      = error_q;
   assign retry_cnt  = retry_q;

endmodule
